date_calendar: RTL and testbench

//   BCD day/month/year calendar stage, directly downstream of the hour counter.

---
 rtl/calendar_pkg.sv | 39 +++
 rtl/date_calendar_bcd2_step.sv | 18 +
 rtl/date_calendar.sv | 145 ++++++++++++++
 tb/tb_date_calendar.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// Shared constants and BCD date helpers for the day/month/year calendar stage.
// Leap rule is only valid for the 2000-2099 window.
package calendar_pkg;

    localparam logic [7:0] BCD_00 = 8'h00;
    localparam logic [7:0] BCD_01 = 8'h01;
    localparam logic [7:0] BCD_12 = 8'h12;
    localparam logic [7:0] BCD_28 = 8'h28;
    localparam logic [7:0] BCD_29 = 8'h29;
    localparam logic [7:0] BCD_30 = 8'h30;
    localparam logic [7:0] BCD_31 = 8'h31;
    localparam logic [7:0] BCD_99 = 8'h99;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_REJECT = 2'd3;

    // Year 20ty is a leap year when ty mod 4 == 0, read directly off the digits.
    function automatic logic is_leap_bcd(input logic [7:0] year);
        logic [3:0] u;
        u = year[3:0];
        if (!year[4]) return (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
        else          return (u == 4'd2) || (u == 4'd6);
    endfunction

    function automatic logic [7:0] dim_bcd(input logic [7:0] month, input logic leap);
        case (month)
            8'h02:                      return leap ? BCD_29 : BCD_28;
            8'h04, 8'h06, 8'h09, 8'h11: return BCD_30;
            default:                    return BCD_31;
        endcase
    endfunction

    function automatic logic bcd_valid(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/date_calendar_bcd2_step.sv
// Two-digit BCD incrementer: returns load_val once cur reaches wrap_at, else cur+1.
// Values above wrap_at also wrap, so a corrupt field cannot count upward forever.
module bcd2_step (
    input  logic [7:0] cur,
    input  logic [7:0] wrap_at,
    input  logic [7:0] load_val,
    output logic [7:0] next,
    output logic       wrapped
);

    always_comb begin
        wrapped = (cur >= wrap_at);
        if (wrapped)                next = load_val;
        else if (cur[3:0] >= 4'd9)  next = {cur[7:4] + 4'd1, 4'd0};
        else                        next = {cur[7:4], cur[3:0] + 4'd1};
    end

endmodule

// File: rtl/date_calendar.sv
// BCD day/month/year calendar advanced by the hour stage's day_inc pulse,
// with a validated three-step load path (capture, check, commit/reject).
module date_calendar
    import calendar_pkg::*;
#(
    parameter logic [7:0] DAY_RST   = 8'h01,
    parameter logic [7:0] MONTH_RST = 8'h01,
    parameter logic [7:0] YEAR_RST  = 8'h00
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       day_inc,
    input  logic       set_req,
    input  logic [7:0] set_day,
    input  logic [7:0] set_month,
    input  logic [7:0] set_year,
    output logic [7:0] day_bcd,
    output logic [7:0] month_bcd,
    output logic [7:0] year_bcd,
    output logic       leap,
    output logic       year_rco,
    output logic       busy,
    output logic       set_ack,
    output logic       set_err
);

    logic [1:0] state_q, state_d;
    logic [7:0] day_q, day_d, month_q, month_d, year_q, year_d;
    logic [7:0] sh_day_q, sh_day_d, sh_month_q, sh_month_d, sh_year_q, sh_year_d;
    logic       leap_q, leap_d, rco_q, rco_d, ack_q, ack_d, err_q, err_d;
    logic       arm_q, arm_d;

    logic [7:0] dim_cur, day_next, month_next, year_next;
    logic       day_wrap, month_wrap, year_wrap, date_bad, set_ok;

    assign dim_cur = dim_bcd(month_q, is_leap_bcd(year_q));

    bcd2_step u_day   (.cur(day_q),   .wrap_at(dim_cur), .load_val(BCD_01),
                       .next(day_next),   .wrapped(day_wrap));
    bcd2_step u_month (.cur(month_q), .wrap_at(BCD_12),  .load_val(BCD_01),
                       .next(month_next), .wrapped(month_wrap));
    bcd2_step u_year  (.cur(year_q),  .wrap_at(BCD_99),  .load_val(BCD_00),
                       .next(year_next),  .wrapped(year_wrap));

    assign date_bad = !bcd_valid(day_q) || !bcd_valid(month_q) ||
                      (month_q == BCD_00) || (month_q > BCD_12) ||
                      (day_q == BCD_00) || (day_q > dim_cur);

    assign set_ok = bcd_valid(sh_day_q) && bcd_valid(sh_month_q) && bcd_valid(sh_year_q) &&
                    (sh_month_q != BCD_00) && (sh_month_q <= BCD_12) && (sh_day_q != BCD_00) &&
                    (sh_day_q <= dim_bcd(sh_month_q, is_leap_bcd(sh_year_q)));

    always_comb begin
        state_d    = state_q;
        day_d      = day_q;
        month_d    = month_q;
        year_d     = year_q;
        sh_day_d   = sh_day_q;
        sh_month_d = sh_month_q;
        sh_year_d  = sh_year_q;
        leap_d     = is_leap_bcd(year_q);
        rco_d      = 1'b0;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        // A held set_req re-arms only after it has been seen low.
        arm_d      = set_req ? arm_q : 1'b1;
        case (state_q)
            ST_RUN: begin
                if (set_req && arm_q) begin
                    sh_day_d   = set_day;
                    sh_month_d = set_month;
                    sh_year_d  = set_year;
                    arm_d      = 1'b0;
                    state_d    = ST_CHECK;
                end else if (day_inc) begin
                    if (date_bad) begin
                        day_d   = BCD_01;
                        month_d = BCD_01;
                    end else begin
                        day_d = day_next;
                        if (day_wrap) begin
                            month_d = month_next;
                            if (month_wrap) begin
                                year_d = year_next;
                                rco_d  = year_wrap;
                            end
                        end
                    end
                end
            end
            ST_CHECK:  state_d = set_ok ? ST_COMMIT : ST_REJECT;
            ST_COMMIT: begin
                day_d   = sh_day_q;
                month_d = sh_month_q;
                year_d  = sh_year_q;
                ack_d   = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                err_d   = 1'b1;
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_RUN;
            day_q      <= DAY_RST;
            month_q    <= MONTH_RST;
            year_q     <= YEAR_RST;
            sh_day_q   <= BCD_00;
            sh_month_q <= BCD_00;
            sh_year_q  <= BCD_00;
            leap_q     <= is_leap_bcd(YEAR_RST);
            rco_q      <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            arm_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            day_q      <= day_d;
            month_q    <= month_d;
            year_q     <= year_d;
            sh_day_q   <= sh_day_d;
            sh_month_q <= sh_month_d;
            sh_year_q  <= sh_year_d;
            leap_q     <= leap_d;
            rco_q      <= rco_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            arm_q      <= arm_d;
        end
    end

    assign day_bcd   = day_q;
    assign month_bcd = month_q;
    assign year_bcd  = year_q;
    assign leap      = leap_q;
    assign year_rco  = rco_q;
    assign busy      = (state_q != ST_RUN);
    assign set_ack   = ack_q;
    assign set_err   = err_q;

endmodule

// File: tb/tb_date_calendar.sv
// Directed bench for date_calendar: an integer date model feeds an expected-date
// queue that is popped when the DUT commits a set or applies an increment.
module tb_date_calendar;

    logic       clk = 1'b0;
    logic       clr, day_inc, set_req;
    logic [7:0] set_day, set_month, set_year;
    logic [7:0] day_bcd, month_bcd, year_bcd;
    logic       leap, year_rco, busy, set_ack, set_err;

    logic [23:0] exp_q[$];
    int md, mm, my;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    date_calendar #(.DAY_RST(8'h01), .MONTH_RST(8'h01), .YEAR_RST(8'h00)) dut (
        .clk(clk), .clr(clr), .day_inc(day_inc), .set_req(set_req),
        .set_day(set_day), .set_month(set_month), .set_year(set_year),
        .day_bcd(day_bcd), .month_bcd(month_bcd), .year_bcd(year_bcd),
        .leap(leap), .year_rco(year_rco), .busy(busy),
        .set_ack(set_ack), .set_err(set_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int dim_i(input int m, input int y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic logic [23:0] model_date();
        return {to_bcd(md), to_bcd(mm), to_bcd(my)};
    endfunction

    task automatic chk_date(input string tag);
        logic [23:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {8'h00, day_bcd, month_bcd, year_bcd}, {8'h00, e});
        end
    endtask

    task automatic do_set(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y);
        bit ok;
        int dd, dm, dy;
        ok = (d[7:4] <= 9) && (d[3:0] <= 9) && (m[7:4] <= 9) && (m[3:0] <= 9) &&
             (y[7:4] <= 9) && (y[3:0] <= 9);
        dd = d[7:4] * 10 + d[3:0];
        dm = m[7:4] * 10 + m[3:0];
        dy = y[7:4] * 10 + y[3:0];
        if (ok) ok = (dm >= 1) && (dm <= 12) && (dd >= 1) && (dd <= dim_i(dm, dy));
        if (ok) begin
            md = dd; mm = dm; my = dy;
        end
        exp_q.push_back(model_date());
        set_day = d; set_month = m; set_year = y;
        set_req = 1'b1;
        tick;
        set_req = 1'b0;
        chk("set_busy", busy, 1);
        tick;
        chk("set_no_early_pulse", {set_ack, set_err}, 0);
        tick;
        chk("set_ack", set_ack, ok);
        chk("set_err", set_err, !ok);
        chk("set_busy_done", busy, 0);
        chk_date("set_date");
        tick;
        chk("set_pulse_end", {set_ack, set_err}, 0);
    endtask

    task automatic do_inc;
        bit rco;
        rco = 1'b0;
        if (md < dim_i(mm, my)) md++;
        else if (mm < 12) begin md = 1; mm++; end
        else begin md = 1; mm = 1; rco = (my == 99); my = (my + 1) % 100; end
        exp_q.push_back(model_date());
        day_inc = 1'b1;
        tick;
        day_inc = 1'b0;
        chk_date("inc_date");
        chk("inc_rco", year_rco, rco);
    endtask

    initial begin
        int acks;
        clr = 1'b1; day_inc = 1'b0; set_req = 1'b0;
        set_day = 8'h00; set_month = 8'h00; set_year = 8'h00;
        md = 1; mm = 1; my = 0;

        // 1: reset state
        #12 clr = 1'b0;
        repeat (5) tick;
        exp_q.push_back(model_date());
        chk_date("reset_date");
        chk("reset_leap", leap, 1);
        chk("reset_pulses", {year_rco, set_ack, set_err, busy}, 0);

        // 2: February in common and leap years
        do_set(8'h28, 8'h02, 8'h01);
        do_inc;
        do_set(8'h28, 8'h02, 8'h04);
        do_inc;
        do_inc;

        // 3: century-style wrap of the 2-digit year
        do_set(8'h31, 8'h12, 8'h99);
        tick;
        chk("leap_99", leap, 0);
        do_inc;
        tick;
        chk("rco_one_cycle", year_rco, 0);
        chk("leap_00", leap, 1);

        // 4: rejected and accepted sets
        do_set(8'h31, 8'h04, 8'h05);
        do_set(8'h1A, 8'h01, 8'h05);
        do_set(8'h30, 8'h04, 8'h05);
        do_inc;

        // BCD digit carries 09->10 and 29->30->31->next month
        do_set(8'h09, 8'h07, 8'h20);
        do_inc;
        do_set(8'h29, 8'h01, 8'h07);
        repeat (3) do_inc;

        // random years around end of February
        for (int k = 0; k < 4; k++) begin
            do_set(8'h28, 8'h02, to_bcd($urandom_range(0, 99)));
            do_inc;
            do_inc;
        end

        // 5: increment during CHECK is dropped
        md = 15; mm = 6; my = 10;
        exp_q.push_back(model_date());
        set_day = 8'h15; set_month = 8'h06; set_year = 8'h10;
        set_req = 1'b1;
        tick;
        set_req = 1'b0;
        day_inc = 1'b1;
        tick;
        day_inc = 1'b0;
        tick;
        chk("chk_inc_ack", set_ack, 1);
        chk_date("chk_inc_date");
        tick;
        exp_q.push_back(model_date());
        chk_date("chk_inc_date_hold");

        // held set_req yields exactly one load
        md = 10; mm = 10; my = 10;
        set_day = 8'h10; set_month = 8'h10; set_year = 8'h10;
        set_req = 1'b1;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (set_ack) acks++;
        end
        set_req = 1'b0;
        chk("held_req_one_ack", acks, 1);
        chk("held_req_idle", busy, 0);
        exp_q.push_back(model_date());
        chk_date("held_req_date");
        tick;

        // 6: asynchronous clear in CHECK
        set_day = 8'h01; set_month = 8'h02; set_year = 8'h03;
        set_req = 1'b1;
        tick;
        set_req = 1'b0;
        chk("clr_in_check_busy", busy, 1);
        #2 clr = 1'b1;
        #1;
        md = 1; mm = 1; my = 0;
        exp_q.push_back(model_date());
        chk_date("clr_async_date");
        chk("clr_async_busy", busy, 0);
        clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("clr_no_pulse", {set_ack, set_err, busy}, 0);
        end
        exp_q.push_back(model_date());
        chk_date("clr_date_kept");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
